// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the scheduler state encoding and the byte, id and counter widths.
package uart_pkg;

   localparam int BYTE_W = 8;
   localparam int ID_W   = 3;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      START,
      WAIT_DONE,
      GAP
   } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker, reusable for any shared resource.
// Ports: i_req request vector, i_ptr last winner, o_win chosen index, o_valid any request.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]    i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic [ID_W-1:0] o_win,
   output logic            o_valid
);

   // The winner is the requester with the smallest rotational distance
   // past the pointer, so ptr+1 is searched first and ptr itself last.
   always_comb begin : p_pick
      int w_best;
      int w_dist;
      w_best  = N;
      w_dist  = 0;
      o_win   = '0;
      o_valid = 1'b0;
      for (int j = 0; j < N; j++) begin
         w_dist = (j - int'(i_ptr) - 1 + 2 * N) % N;
         if (i_req[j] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_win   = ID_W'(j);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers, round-robin.
// Ports: clk, i_reset (sync, high), i_req/i_req_data from clients, o_grant
//        accept pulse, o_tx_data/o_tx_start/i_tx_finished to the transmitter,
//        o_busy, o_active_id owner index, o_timeout abort pulse.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                        clk,
   input  logic                        i_reset,
   input  logic [NUM_REQ-1:0]          i_req,
   input  logic [BYTE_W*NUM_REQ-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]          o_grant,
   output logic [BYTE_W-1:0]           o_tx_data,
   output logic                        o_tx_start,
   input  logic                        i_tx_finished,
   output logic                        o_busy,
   output logic [ID_W-1:0]             o_active_id,
   output logic                        o_timeout
);

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   // A zero gap still spends one cycle in GAP.
   localparam logic [CNT_W-1:0] GAP_LAST =
      (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
   localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

   sched_state_t          r_state;
   sched_state_t          w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [ID_W-1:0]       r_ptr;
   logic [NUM_REQ-1:0]    r_grant;
   logic [BYTE_W-1:0]     r_tx_data;
   logic                  r_tx_start;
   logic                  r_busy;
   logic [ID_W-1:0]       r_active_id;
   logic                  r_timeout;

   logic [ID_W-1:0]       w_win;
   logic                  w_valid;
   logic                  w_to_hit;
   logic                  w_gap_done;
   logic                  w_load;
   logic                  w_start_nxt;
   logic                  w_timeout_nxt;
   logic [NUM_REQ-1:0]    w_grant_nxt;
   logic [BYTE_W-1:0]     w_sel_data;

   rr_arbiter #(
      .N       (NUM_REQ)
   ) u_arb (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   assign w_to_hit   = (r_cnt == TO_LAST);
   assign w_gap_done = (r_cnt >= GAP_LAST);

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:      if (w_valid) w_state_nxt = LATCH;
         LATCH:     w_state_nxt = START;
         START:     w_state_nxt = WAIT_DONE;
         WAIT_DONE: if (i_tx_finished || w_to_hit) w_state_nxt = GAP;
         GAP:       if (w_gap_done) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; finished beats a same-cycle timeout.
   always_comb begin
      w_load        = (r_state == IDLE) && w_valid;
      w_start_nxt   = (r_state == LATCH);
      w_timeout_nxt = (r_state == WAIT_DONE) && !i_tx_finished && w_to_hit;
      w_grant_nxt   = '0;
      w_sel_data    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_win == ID_W'(k)) begin
            w_grant_nxt[k] = w_load;
            w_sel_data     = i_req_data[k*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_cnt       <= '0;
         r_ptr       <= PTR_RST;
         r_grant     <= '0;
         r_tx_data   <= '0;
         r_tx_start  <= 1'b0;
         r_busy      <= 1'b0;
         r_active_id <= '0;
         r_timeout   <= 1'b0;
      end else begin
         // One counter serves WAIT_DONE and GAP; it restarts on every state change.
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if ((r_state == WAIT_DONE) || (r_state == GAP)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_load) begin
            r_ptr       <= w_win;
            r_tx_data   <= w_sel_data;
            r_active_id <= w_win;
         end
         r_grant    <= w_grant_nxt;
         r_tx_start <= w_start_nxt;
         r_timeout  <= w_timeout_nxt;
         r_busy     <= (w_state_nxt != IDLE);
      end
   end

   assign o_grant     = r_grant;
   assign o_tx_data   = r_tx_data;
   assign o_tx_start  = r_tx_start;
   assign o_busy      = r_busy;
   assign o_active_id = r_active_id;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler against a transaction-level model.
// A second instance with a zero gap checks back-to-back spacing.
module tb_uart_tx_scheduler;

   localparam int N  = 4;
   localparam int G  = 3;
   localparam int TO = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [8*N-1:0] data;
   logic           fin;
   logic [N-1:0]   o_grant;
   logic [7:0]     o_tx_data;
   logic           o_tx_start;
   logic           o_busy;
   logic [2:0]     o_active_id;
   logic           o_timeout;

   logic [N-1:0]   b_req;
   logic [8*N-1:0] b_data;
   logic           b_fin;
   logic [N-1:0]   b_grant;
   logic [7:0]     b_tx_data;
   logic           b_start;
   logic           b_busy;
   logic [2:0]     b_id;
   logic           b_timeout;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int exp_ptr;
   logic [7:0] exp_data;
   int exp_id;
   int last_win;
   int t_start    = 0;
   int prev_start = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_scheduler #(
      .NUM_REQ        (N),
      .GAP_CYCLES     (G),
      .TIMEOUT_CYCLES (TO)
   ) u_dut (
      .clk           (clk),
      .i_reset       (rst),
      .i_req         (req),
      .i_req_data    (data),
      .o_grant       (o_grant),
      .o_tx_data     (o_tx_data),
      .o_tx_start    (o_tx_start),
      .i_tx_finished (fin),
      .o_busy        (o_busy),
      .o_active_id   (o_active_id),
      .o_timeout     (o_timeout)
   );

   uart_tx_scheduler #(
      .NUM_REQ        (N),
      .GAP_CYCLES     (0),
      .TIMEOUT_CYCLES (TO)
   ) u_dut_g0 (
      .clk           (clk),
      .i_reset       (rst),
      .i_req         (b_req),
      .i_req_data    (b_data),
      .o_grant       (b_grant),
      .o_tx_data     (b_tx_data),
      .o_tx_start    (b_start),
      .i_tx_finished (b_fin),
      .o_busy        (b_busy),
      .o_active_id   (b_id),
      .o_timeout     (b_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      logic [N-1:0] one;
      one = 1;
      for (int k = 1; k <= N; k++) begin
         if ((r & (one << ((p + k) % N))) != '0) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [7:0] byte_of(input logic [8*N-1:0] d,
                                          input int k);
      return d[k*8 +: 8];
   endfunction

   task automatic chk_reset_state;
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_grant", 32'(o_grant), 0);
      chk("rst_start", 32'(o_tx_start), 0);
      chk("rst_timeout", 32'(o_timeout), 0);
      chk("rst_data", 32'(o_tx_data), 0);
      chk("rst_id", 32'(o_active_id), 0);
      exp_ptr  = N - 1;
      exp_data = '0;
      exp_id   = 0;
   endtask

   task automatic do_reset;
      req = '0;
      fin = 1'b0;
      rst = 1'b1;
      repeat (2) tick;
      rst = 1'b0;
      chk_reset_state;
   endtask

   // Starts in an IDLE cycle; ends in the next IDLE cycle.
   task automatic run_frame(input logic [N-1:0] rv, input int d,
                            input bit drop, input int rst_at);
      int win;
      int glen;
      logic [7:0] wdat;
      logic [N-1:0] one;
      one = 1;
      req = rv;
      win = rr_pick(rv, exp_ptr);
      if (win < 0) begin
         fin = 1'b1;
         tick;
         fin = 1'b0;
         chk("idle_busy", 32'(o_busy), 0);
         chk("idle_grant", 32'(o_grant), 0);
         return;
      end
      wdat = byte_of(data, win);
      tick;
      chk("grant", 32'(o_grant), 32'(one << win));
      chk("tx_data", 32'(o_tx_data), 32'(wdat));
      chk("active_id", 32'(o_active_id), win);
      chk("latch_start", 32'(o_tx_start), 0);
      exp_ptr  = win;
      exp_data = wdat;
      exp_id   = win;
      last_win = win;
      tick;
      chk("start", 32'(o_tx_start), 1);
      chk("start_grant", 32'(o_grant), 0);
      prev_start = t_start;
      t_start    = cyc;
      if (drop) req[win] = 1'b0;
      else data[win*8 +: 8] = 8'($urandom);
      for (int j = 1; j <= TO; j++) begin
         tick;
         if (j == rst_at) begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            fin = 1'b0;
            chk_reset_state;
            return;
         end
         chk("wait_flags", 32'({o_tx_start, o_timeout, o_busy}), 1);
         chk("wait_data", 32'(o_tx_data), 32'(exp_data));
         if (j == d) fin = 1'b1;
         if (j >= d) break;
      end
      tick;
      fin = 1'b0;
      chk("gap_timeout", 32'(o_timeout), (d > TO) ? 1 : 0);
      chk("gap_busy", 32'(o_busy), 1);
      glen = (G > 0) ? G : 1;
      for (int g = 2; g <= glen; g++) begin
         fin = ($urandom_range(0, 3) == 0);
         tick;
         chk("gap_hold", 32'({o_busy, o_timeout}), 2);
      end
      tick;
      fin = 1'b0;
      chk("end_busy", 32'(o_busy), 0);
      chk("held_data", 32'(o_tx_data), 32'(exp_data));
      chk("held_id", 32'(o_active_id), exp_id);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int order [5];
      int nst;
      int last;
      int low;
      bit seen;
      int d;
      int r;
      order  = '{0, 1, 2, 3, 0};
      rst    = 1'b1;
      req    = '0;
      data   = '0;
      fin    = 1'b0;
      b_req  = '0;
      b_data = '0;
      b_fin  = 1'b0;
      do_reset;

      data[23:16] = 8'hA5;
      run_frame(4'b0100, 5, 1'b1, 0);
      chk("t1_winner", last_win, 2);

      data = 32'($urandom);
      run_frame(4'b0001, TO, 1'b1, 0);
      data = 32'($urandom);
      run_frame(4'b0010, TO + 20, 1'b1, 0);

      data = 32'($urandom);
      run_frame(4'b1000, 20, 1'b0, 7);
      data = 32'($urandom);
      run_frame(4'b1001, 4, 1'b1, 0);
      chk("t5_after_rst", last_win, 0);

      do_reset;
      data = 32'($urandom);
      for (int f = 0; f < 5; f++) begin
         run_frame(4'b1111, 10, 1'b0, 0);
         chk("rr_order", last_win, order[f]);
         if (f > 0) chk("rr_space", t_start - prev_start, 13 + G);
      end

      run_frame(4'b0011, 4, 1'b0, 0);
      run_frame(4'b0100, 4, 1'b0, 0);
      chk("t6_lost", last_win, 2);

      for (int it = 0; it < 30; it++) begin
         data = 32'($urandom);
         r    = $urandom_range(0, 9);
         if (r == 0)      d = TO;
         else if (r == 1) d = TO + $urandom_range(1, 5);
         else             d = $urandom_range(1, 15);
         run_frame(4'($urandom), d, 1'($urandom),
                   ($urandom_range(0, 14) == 0) ? $urandom_range(1, 3) : 0);
      end

      req    = '0;
      b_req  = 4'b1111;
      b_data = 32'($urandom);
      nst    = 0;
      last   = 0;
      low    = 0;
      seen   = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick;
         b_fin = seen;
         seen  = b_start;
         if (!b_busy) low++;
         if (b_start) begin
            if (nst > 0) begin
               chk("g0_space", cyc - last, 5);
               chk("g0_idle", low, 1);
            end
            chk("g0_id", 32'(b_id), nst % N);
            last = cyc;
            low  = 0;
            nst++;
         end
      end
      chk("g0_starts", 32'(nst >= 10), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
